tt_sweep_checker: RTL and testbench

- Upstream/downstream harness stage for the 3-input synthesized genetic-logic netlists (NOR/NOT structural modules such as m0x42).
- On start, drives all 8 input vectors into the combinational DUT, waits a settle interval, double-samples the DUT output and assembles the measured 8-bit truth table.
- Compares the measured table against an expected table and reports pass/fail, mismatch bits and instability bits for circuit-score regression.

---
 rtl/tt_sweep_checker_pkg.sv | 21 ++
 rtl/tt_sweep_checker_settle_timer.sv | 40 ++++
 rtl/tt_sweep_checker.sv | 182 ++++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package tt_pkg;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned TT_W    = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE_A,
        SAMPLE_B,
        DONE
    } tt_state_e;

    // Vector index to DUT drive bits {in1, in2, in3}; in1 is the index MSB.
    function automatic logic [2:0] vec_to_drv(input logic [IDX_W-1:0] idx);
        return {idx[2], idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/tt_sweep_checker_settle_timer.sv
// Settle-interval down-counter: load at the start of a window, expire on the
// last cycle of the window.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload, or count down while the window is open.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expire = en && (cnt_q == '0);

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 8 input vectors of a 3-input combinational netlist, double-samples
// its output per vector and compares the measured truth table to an expected one.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned N_IN          = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected_tt,
    input  logic            dut_out,
    output logic            drv_in1,
    output logic            drv_in2,
    output logic            drv_in3,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [TT_W-1:0] tt_meas,
    output logic [TT_W-1:0] mismatch_mask,
    output logic [TT_W-1:0] unstable_mask,
    output logic            pass
);

    localparam int unsigned       VEC_LAST  = (1 << N_IN) - 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(VEC_LAST);
    // With no settle time each vector window starts directly at the first sample.
    localparam tt_state_e         VEC_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE_A : SETTLE;

    tt_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       drv_q, drv_d;
    logic             sample_a_q, sample_a_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic [TT_W-1:0]  tt_q, tt_d;
    logic [TT_W-1:0]  mism_q, mism_d;
    logic [TT_W-1:0]  unst_q, unst_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic tmr_load;
    logic tmr_expire;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .en    (state_q == SETTLE),
        .expire(tmr_expire)
    );

    // Next-state and registered-output logic for the sweep FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        drv_d      = drv_q;
        sample_a_d = sample_a_q;
        exp_d      = exp_q;
        tt_d       = tt_q;
        mism_d     = mism_q;
        unst_d     = unst_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        aborted_d  = aborted_q;
        tmr_load   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d     = expected_tt;
                    tt_d      = '0;
                    mism_d    = '0;
                    unst_d    = '0;
                    pass_d    = 1'b0;
                    aborted_d = 1'b0;
                    idx_d     = '0;
                    drv_d     = vec_to_drv('0);
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
                    state_d   = VEC_ENTRY;
                end
            end
            SETTLE: begin
                if (tmr_expire) begin
                    state_d = SAMPLE_A;
                end
            end
            SAMPLE_A: begin
                sample_a_d = dut_out;
                state_d    = SAMPLE_B;
            end
            SAMPLE_B: begin
                tt_d[idx_q]   = dut_out;
                unst_d[idx_q] = dut_out ^ sample_a_q;
                if (idx_q == IDX_LAST) begin
                    mism_d  = tt_d ^ exp_q;
                    pass_d  = (mism_d == '0) && (unst_d == '0);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    drv_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    drv_d    = vec_to_drv(idx_d);
                    tmr_load = 1'b1;
                    state_d  = VEC_ENTRY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the running state planned, including a final
        // capture, so no done pulse can follow it; captured bits so far are kept.
        if (abort && busy_q) begin
            state_d   = IDLE;
            tt_d      = tt_q;
            unst_d    = unst_q;
            mism_d    = mism_q;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
            drv_d     = '0;
            tmr_load  = 1'b0;
        end
    end

    // FSM state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            drv_q      <= '0;
            sample_a_q <= 1'b0;
            exp_q      <= '0;
            tt_q       <= '0;
            mism_q     <= '0;
            unst_q     <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            drv_q      <= drv_d;
            sample_a_q <= sample_a_d;
            exp_q      <= exp_d;
            tt_q       <= tt_d;
            mism_q     <= mism_d;
            unst_q     <= unst_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    assign drv_in1       = drv_q[2];
    assign drv_in2       = drv_q[1];
    assign drv_in3       = drv_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign tt_meas       = tt_q;
    assign mismatch_mask = mism_q;
    assign unstable_mask = unst_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker: one instance with a 4-cycle settle,
// one with no settle, both driving an m0x42 model.
module tb_tt_sweep_checker;

    typedef struct {
        logic [7:0]  tt;
        logic [7:0]  care;
        logic [7:0]  mism;
        logic [7:0]  unst;
        logic        pass;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    exp_t q4[$];
    exp_t q0[$];
    exp_t e4, e0;

    // Instance with SETTLE_CYCLES = 4
    logic       start4, abort4, dout4, d41, d42, d43, busy4, done4, aborted4, pass4;
    logic [7:0] ett4, tt4, mism4, unst4;
    logic [2:0] drv4;
    logic       tog_en, tog_q;

    // Instance with SETTLE_CYCLES = 0
    logic       start0, abort0, dout0, d01, d02, d03, busy0, done0, aborted0, pass0;
    logic [7:0] ett0, tt0, mism0, unst0;
    logic [2:0] drv0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial tog_q = 1'b0;
    always @(posedge clk) tog_q <= ~tog_q;

    function automatic logic m0x42(input logic [2:0] v);
        return v[2] ? (v[1] & ~v[0]) : (v[0] & ~v[1]);
    endfunction

    function automatic logic [7:0] model_tt();
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t[i] = m0x42(3'(i));
        return t;
    endfunction

    assign drv4  = {d41, d42, d43};
    assign drv0  = {d01, d02, d03};
    assign dout4 = (tog_en && drv4 == 3'd5) ? tog_q : m0x42(drv4);
    assign dout0 = m0x42(drv0);

    tt_sweep_checker #(.SETTLE_CYCLES(4), .N_IN(3)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4), .expected_tt(ett4),
        .dut_out(dout4), .drv_in1(d41), .drv_in2(d42), .drv_in3(d43),
        .busy(busy4), .done(done4), .aborted(aborted4), .tt_meas(tt4),
        .mismatch_mask(mism4), .unstable_mask(unst4), .pass(pass4)
    );

    tt_sweep_checker #(.SETTLE_CYCLES(0), .N_IN(3)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected_tt(ett0),
        .dut_out(dout0), .drv_in1(d01), .drv_in2(d02), .drv_in3(d03),
        .busy(busy0), .done(done0), .aborted(aborted0), .tt_meas(tt0),
        .mismatch_mask(mism0), .unstable_mask(unst0), .pass(pass0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t make_exp(input logic [7:0] ett, input logic tog,
                                      input int unsigned t, input int unsigned settle);
        exp_t e;
        e.tt   = model_tt();
        e.care = tog ? 8'hDF : 8'hFF;
        e.mism = (e.tt ^ ett) & e.care;
        e.unst = tog ? 8'h20 : 8'h00;
        e.pass = (e.mism == 8'h00) && (e.unst == 8'h00);
        e.cyc  = t + 1 + 8 * (settle + 2);
        return e;
    endfunction

    // Scoreboard for the 4-cycle instance: compare on each done pulse.
    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                check("dut4_unexpected_done", {31'b0, done4}, 32'd0);
            end else begin
                e4 = q4.pop_front();
                check("dut4_done_cycle", cyc, e4.cyc);
                check("dut4_tt_meas", tt4 & e4.care, e4.tt & e4.care);
                check("dut4_mismatch", mism4 & e4.care, e4.mism);
                check("dut4_unstable", unst4, e4.unst);
                check("dut4_pass", pass4, e4.pass);
                check("dut4_busy_at_done", busy4, 0);
                check("dut4_drv_at_done", drv4, 0);
            end
        end
    end

    // Scoreboard for the zero-settle instance.
    always @(negedge clk) begin
        if (done0) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_done", {31'b0, done0}, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_done_cycle", cyc, e0.cyc);
                check("dut0_tt_meas", tt0, e0.tt);
                check("dut0_mismatch", mism0, e0.mism);
                check("dut0_unstable", unst0, e0.unst);
                check("dut0_pass", pass0, e0.pass);
            end
        end
    end

    task automatic launch4(input logic [7:0] ett, input logic tog, input logic expect_done,
                           output int unsigned t);
        ett4   = ett;
        start4 = 1'b1;
        t      = cyc;
        if (expect_done) q4.push_back(make_exp(ett, tog, t, 4));
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic drain4();
        for (int i = 0; i < 300 && q4.size() != 0; i++) @(negedge clk);
        check("dut4_drain", q4.size(), 0);
        @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_all_zero4(input string tag);
        check({tag, "_busy"}, busy4, 0);
        check({tag, "_done"}, done4, 0);
        check({tag, "_aborted"}, aborted4, 0);
        check({tag, "_pass"}, pass4, 0);
        check({tag, "_drv"}, drv4, 0);
        check({tag, "_tt"}, tt4, 0);
        check({tag, "_mism"}, mism4, 0);
        check({tag, "_unst"}, unst4, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned t;
        rst = 1'b1; start4 = 1'b0; abort4 = 1'b0; ett4 = '0; tog_en = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; ett0 = '0;
        repeat (3) @(negedge clk);
        check_all_zero4("reset");
        check("reset_dut0_busy", busy0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Matching table; a start mid-sweep (with a different table) is ignored.
        launch4(8'h42, 1'b0, 1'b1, t);
        check("dut4_busy_after_start", busy4, 1);
        check("dut4_drv_vec0", drv4, 0);
        wait_until(t + 10);
        ett4 = 8'hFF; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("dut4_busy_after_ignored_start", busy4, 1);
        drain4();
        repeat (3) @(negedge clk);
        check("dut4_hold_tt", tt4, model_tt());
        check("dut4_hold_pass", pass4, 1);

        // Mismatching expected table.
        launch4(8'h24, 1'b0, 1'b1, t);
        drain4();

        // Output toggling only while vector 5 is driven.
        tog_en = 1'b1;
        launch4(8'h42, 1'b1, 1'b1, t);
        drain4();
        tog_en = 1'b0;

        // Abort at T+20: vectors 0..2 already captured.
        launch4(8'h42, 1'b0, 1'b0, t);
        wait_until(t + 20);
        check("dut4_busy_before_abort", busy4, 1);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        check("abort_busy", busy4, 0);
        check("abort_aborted", aborted4, 1);
        check("abort_drv", drv4, 0);
        check("abort_pass", pass4, 0);
        check("abort_partial_tt", tt4, model_tt() & 8'h07);
        repeat (40) @(negedge clk);
        check("abort_aborted_holds", aborted4, 1);

        // Reset at T+30 mid-sweep.
        launch4(8'h42, 1'b0, 1'b0, t);
        check("dut4_aborted_cleared", aborted4, 0);
        wait_until(t + 30);
        check("dut4_tt_partial_before_rst", tt4, model_tt() & 8'h0F);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero4("midrst");
        repeat (40) @(negedge clk);

        // Fresh sweep after reset.
        launch4(8'h42, 1'b0, 1'b1, t);
        drain4();

        // Zero-settle instance: drv steps every 2 cycles, done at T+17.
        ett0   = 8'h42;
        start0 = 1'b1;
        t      = cyc;
        q0.push_back(make_exp(8'h42, 1'b0, t, 0));
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("dut0_drv_seq", drv0, k);
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < 100 && q0.size() != 0; i++) @(negedge clk);
        check("dut0_drain", q0.size(), 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
